// File: rtl/flappy_game_ctrl_pkg.sv
// Shared geometry, motion constants and state encoding for the flappy game sequencer.
// The colour stage imports this package so both blocks agree on sprite geometry.
package flappy_game_ctrl_pkg;

  typedef logic [10:0]        coord_t;
  typedef logic signed [5:0]  vel_t;

  localparam coord_t X_BIRD       = 11'd80;
  localparam coord_t BIRD_W       = 11'd30;
  localparam coord_t BIRD_H       = 11'd40;
  localparam coord_t PIPE_W       = 11'd30;
  localparam coord_t PIPE_GAP     = 11'd140;
  localparam coord_t SCREEN_W     = 11'd640;
  localparam coord_t SCREEN_H     = 11'd480;
  localparam coord_t PIPE_SPACING = 11'd340;
  localparam coord_t PIPE_SPEED   = 11'd2;
  localparam coord_t BIRD_Y0      = 11'd240;
  localparam coord_t Y_MIN        = 11'd180;
  localparam coord_t Y_PIPE_START = 11'd300;

  localparam coord_t X_PIPE0_START = SCREEN_W + PIPE_W;
  localparam coord_t X_PIPE1_START = SCREEN_W + PIPE_W + PIPE_SPACING;
  localparam coord_t PIPE_WRAP_ADD = coord_t'(2 * PIPE_SPACING - PIPE_SPEED);

  localparam vel_t GRAVITY  = 6'sd1;
  localparam vel_t FLAP_VEL = 6'sd8;
  localparam vel_t VMAX     = 6'sd10;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } gameState_t;

  // Gap test rearranged as additions so nothing underflows near the top of the screen.
  function automatic logic pipeHit(coord_t xPipe, coord_t yPipe, coord_t yBird);
    return (X_BIRD + BIRD_W + PIPE_W > xPipe) && (xPipe > X_BIRD) &&
           ((yBird + PIPE_GAP < yPipe + BIRD_H) || (yBird > yPipe));
  endfunction

endpackage

// File: rtl/flappy_game_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pick new pipe heights.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Per-frame game sequencer: bird physics, pipe scrolling/recycling, collisions and score.
module flappy_game_ctrl
  import flappy_game_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        flap,
  output logic [31:0] xPipe0,
  output logic [31:0] xPipe1,
  output logic [31:0] yPipe0,
  output logic [31:0] yPipe1,
  output logic [31:0] yBird,
  output logic [15:0] score,
  output logic [1:0]  state
);

  gameState_t  stateReg;
  coord_t      yBirdReg;
  vel_t        velReg;
  coord_t      xPipeReg [2];
  coord_t      yPipeReg [2];
  logic [15:0] scoreReg;
  logic        flapPrev;
  logic        flapPend;
  logic [15:0] lfsrQ;

  lfsr16 #(.SEED(LFSR_SEED)) uLfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsrQ)
  );

  // An edge arriving on the tick clock still counts for that tick.
  logic flapTake;
  assign flapTake = flapPend | (flap & ~flapPrev);

  coord_t     xPipeNext [2];
  coord_t     yPipeNext [2];
  logic [1:0] passed;
  logic [1:0] hit;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gPipe
      logic wrap;
      assign wrap          = xPipeReg[gi] <= PIPE_SPEED;
      assign xPipeNext[gi] = wrap ? xPipeReg[gi] + PIPE_WRAP_ADD : xPipeReg[gi] - PIPE_SPEED;
      assign yPipeNext[gi] = wrap ? Y_MIN + {3'b000, lfsrQ[8*gi +: 8]} : yPipeReg[gi];
      assign passed[gi]    = (xPipeReg[gi] >= X_BIRD) && (xPipeNext[gi] < X_BIRD);
      assign hit[gi]       = pipeHit(xPipeReg[gi], yPipeReg[gi], yBirdReg);
    end
  endgenerate

  logic crash;
  assign crash = (stateReg == PLAY) && ((yBirdReg >= SCREEN_H) || (|hit));

  vel_t        velInc;
  vel_t        velNext;
  vel_t        velFinal;
  coord_t      ySum;
  coord_t      yFinal;
  logic [16:0] scoreSum;
  logic [15:0] scoreNext;

  always_comb begin
    velInc   = velReg + GRAVITY;
    velNext  = flapTake ? -FLAP_VEL : ((velInc > VMAX) ? VMAX : velInc);
    ySum     = yBirdReg + {{5{velNext[5]}}, velNext};
    velFinal = velNext;
    yFinal   = ySum;
    if ($signed(ySum) < $signed(BIRD_H)) begin
      yFinal   = BIRD_H;
      velFinal = '0;
    end else if ($signed(ySum) >= $signed(SCREEN_H)) begin
      yFinal = SCREEN_H;
    end
    // A new game starts counting from zero on its first frame.
    scoreSum  = {1'b0, (stateReg == PLAY) ? scoreReg : 16'd0} + 17'(passed[0]) + 17'(passed[1]);
    scoreNext = scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
  end

  logic doAdvance;
  logic doRestart;
  assign doAdvance = frame_tick && (((stateReg == PLAY) && !crash) || ((stateReg == IDLE) && flapTake));
  assign doRestart = frame_tick && (stateReg == DEAD) && flapTake;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      yBirdReg    <= BIRD_Y0;
      velReg      <= '0;
      xPipeReg[0] <= X_PIPE0_START;
      xPipeReg[1] <= X_PIPE1_START;
      yPipeReg[0] <= Y_PIPE_START;
      yPipeReg[1] <= Y_PIPE_START;
      scoreReg    <= '0;
      flapPrev    <= 1'b0;
      flapPend    <= 1'b0;
    end else begin
      flapPrev <= flap;
      flapPend <= frame_tick ? 1'b0 : flapTake;
      if (crash) begin
        stateReg <= DEAD;
      end else if (doAdvance) begin
        stateReg <= PLAY;
        yBirdReg <= yFinal;
        velReg   <= velFinal;
        scoreReg <= scoreNext;
        for (int i = 0; i < 2; i++) begin
          xPipeReg[i] <= xPipeNext[i];
          yPipeReg[i] <= yPipeNext[i];
        end
      end else if (doRestart) begin
        stateReg    <= IDLE;
        yBirdReg    <= BIRD_Y0;
        velReg      <= '0;
        xPipeReg[0] <= X_PIPE0_START;
        xPipeReg[1] <= X_PIPE1_START;
        yPipeReg[0] <= Y_PIPE_START;
        yPipeReg[1] <= Y_PIPE_START;
      end
    end
  end

  assign xPipe0 = {21'd0, xPipeReg[0]};
  assign xPipe1 = {21'd0, xPipeReg[1]};
  assign yPipe0 = {21'd0, yPipeReg[0]};
  assign yPipe1 = {21'd0, yPipeReg[1]};
  assign yBird  = {21'd0, yBirdReg};
  assign score  = scoreReg;
  assign state  = stateReg;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Scoreboard bench for flappy_game_ctrl: stimulus pushes expected frames, a monitor pops and compares.
module tb_flappy_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        flap = 1'b0;
  logic [31:0] xPipe0, xPipe1, yPipe0, yPipe1, yBird;
  logic [15:0] score;
  logic [1:0]  state;

  flappy_game_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .flap       (flap),
    .xPipe0     (xPipe0),
    .xPipe1     (xPipe1),
    .yPipe0     (yPipe0),
    .yPipe1     (yPipe1),
    .yBird      (yBird),
    .score      (score),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    string name;
    int    st, yB, x0, x1, yp0, yp1, sc;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   cyc = 0;
  int   nCmp = 0;
  int   nBad = 0;

  // Reference game model, advanced once per clock alongside the DUT.
  int mSt, mY, mVel, mX0, mX1, mYp0, mYp1, mSc, mL;
  bit mFPrev, mFPend;

  function automatic void modelReset();
    mSt = 0; mY = 240; mVel = 0; mX0 = 670; mX1 = 1010; mYp0 = 300; mYp1 = 300;
    mSc = 0; mL = 'hACE1; mFPrev = 0; mFPend = 0;
  endfunction

  function automatic bit pipeHitM(int x, int yp, int y);
    return (80 + 30 > x - 30) && (80 < x) && ((y - 40 < yp - 140) || (y > yp));
  endfunction

  function automatic void modelStep(bit tick, bit fl);
    bit pend;
    bit crash;
    int v, y, nx0, nx1, passes, fb;
    pend  = mFPend || (fl && !mFPrev);
    crash = (mSt == 1) && (mY >= 480 || pipeHitM(mX0, mYp0, mY) || pipeHitM(mX1, mYp1, mY));
    if (crash) begin
      mSt = 2;
    end else if (tick && (mSt == 1 || (mSt == 0 && pend))) begin
      if (mSt == 0) mSc = 0;
      mSt = 1;
      v = pend ? -8 : ((mVel + 1 > 10) ? 10 : mVel + 1);
      y = mY + v;
      if (y < 40) begin y = 40; v = 0; end
      else if (y >= 480) y = 480;
      mY = y; mVel = v;
      if (mX0 <= 2) begin nx0 = mX0 + 678; mYp0 = 180 + (mL & 255); end
      else nx0 = mX0 - 2;
      if (mX1 <= 2) begin nx1 = mX1 + 678; mYp1 = 180 + ((mL >> 8) & 255); end
      else nx1 = mX1 - 2;
      passes = 0;
      if (mX0 >= 80 && nx0 < 80) passes++;
      if (mX1 >= 80 && nx1 < 80) passes++;
      mSc = (mSc + passes > 65535) ? 65535 : mSc + passes;
      mX0 = nx0; mX1 = nx1;
    end else if (tick && mSt == 2 && pend) begin
      mSt = 0; mY = 240; mVel = 0; mX0 = 670; mX1 = 1010; mYp0 = 300; mYp1 = 300;
    end
    mFPend = tick ? 1'b0 : pend;
    mFPrev = fl;
    fb = ((mL >> 15) ^ (mL >> 13) ^ (mL >> 12) ^ (mL >> 10)) & 1;
    mL = ((mL << 1) | fb) & 'hFFFF;
  endfunction

  function automatic void pushModel(string nm);
    exp_t e;
    e.cyc = cyc + 1; e.name = nm;
    e.st = mSt; e.yB = mY; e.x0 = mX0; e.x1 = mX1; e.yp0 = mYp0; e.yp1 = mYp1; e.sc = mSc;
    expQ.push_back(e);
  endfunction

  // Hand-computed expectation; -1 marks a field that is not checked.
  function automatic void pushK(string nm, int st, int yB, int x0, int x1, int yp0, int sc);
    exp_t e;
    e.cyc = cyc + 1; e.name = nm;
    e.st = st; e.yB = yB; e.x0 = x0; e.x1 = x1; e.yp0 = yp0; e.yp1 = -1; e.sc = sc;
    expQ.push_back(e);
  endfunction

  function automatic void applyStep(bit tick, bit fl, string nm, bit forceChk);
    int prevSt;
    prevSt     = mSt;
    frame_tick = tick;
    flap       = fl;
    modelStep(tick, fl);
    if (tick || forceChk) pushModel(nm);
    else if (mSt != prevSt) pushModel("state_change");
  endfunction

  task automatic step(input bit tick, input bit fl, input string nm);
    @(negedge clk);
    applyStep(tick, fl, nm, 1'b0);
  endtask

  task automatic quiet2();
    step(1'b0, 1'b0, "");
    step(1'b0, 1'b0, "");
  endtask

  task automatic frame(input bit fl, input string nm);
    step(1'b1, fl, nm);
    quiet2();
  endtask

  function automatic bit fieldOk(int want, int got);
    return (want < 0) || (want == got);
  endfunction

  always @(posedge clk) begin
    cyc++;
    #1;
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      monE = expQ.pop_front();
      nCmp++;
      if (monE.cyc == cyc && fieldOk(monE.st, int'(state)) && fieldOk(monE.yB, int'(yBird)) &&
          fieldOk(monE.x0, int'(xPipe0)) && fieldOk(monE.x1, int'(xPipe1)) &&
          fieldOk(monE.yp0, int'(yPipe0)) && fieldOk(monE.yp1, int'(yPipe1)) &&
          fieldOk(monE.sc, int'(score))) begin
        $display("ok   %s cyc=%0d st=%0d y=%0d x0=%0d x1=%0d yp0=%0d yp1=%0d sc=%0d",
                 monE.name, cyc, state, yBird, xPipe0, xPipe1, yPipe0, yPipe1, score);
      end else begin
        nBad++;
        $display("FAIL %s cyc=%0d/%0d got st=%0d y=%0d x0=%0d x1=%0d yp0=%0d yp1=%0d sc=%0d want st=%0d y=%0d x0=%0d x1=%0d yp0=%0d yp1=%0d sc=%0d",
                 monE.name, cyc, monE.cyc, state, yBird, xPipe0, xPipe1, yPipe0, yPipe1, score,
                 monE.st, monE.yB, monE.x0, monE.x1, monE.yp0, monE.yp1, monE.sc);
      end
    end
  end

  task automatic boundFail(input string nm);
    nBad++;
    $display("FAIL %s loop bound expired (model st=%0d y=%0d x0=%0d)", nm, mSt, mY, mX0);
  endtask

  initial begin
    int guard, x0b, yPrev, wrapY;
    modelReset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    applyStep(1'b0, 1'b0, "reset", 1'b1);
    pushK("reset_k", 0, 240, 670, 1010, 300, 0);

    frame(1'b0, "idle_tick_no_flap");

    // Flap edge on a quiet clock stays pending until the next tick.
    step(1'b0, 1'b1, "flap_pulse");
    step(1'b0, 1'b0, "");
    step(1'b1, 1'b0, "start");
    pushK("start_k", 1, 232, -1, -1, -1, 0);
    quiet2();

    for (int k = 1; k <= 20; k++) begin
      yPrev = mY;
      step(1'b1, 1'b0, "fall");
      if (k >= 18) pushK("vmax_step", 1, yPrev + 10, -1, -1, -1, -1);
      quiet2();
    end

    // Hover in pipe0's gap until it reaches the wrap column.
    guard = 0;
    while (mX0 != 2 && mSt == 1 && guard < 400) begin
      x0b = mX0;
      step(1'b1, mY > 270, "hover");
      if (x0b == 82) pushK("at80_no_score", 1, -1, 80, -1, -1, 0);
      if (x0b == 80) pushK("passed_pipe0", 1, -1, 78, -1, -1, 1);
      quiet2();
      guard++;
    end
    if (mX0 != 2) boundFail("hover_to_wrap");
    wrapY = 180 + (mL & 255);
    step(1'b1, mY > 270, "wrap");
    pushK("wrap_k", 1, -1, 680, -1, wrapY, 1);
    quiet2();

    guard = 0;
    while (mY - 8 >= 40 && mSt == 1 && guard < 100) begin
      frame(1'b1, "climb");
      guard++;
    end
    if (mY - 8 >= 40) boundFail("climb");
    step(1'b1, 1'b1, "ceiling");
    pushK("ceiling_k", 1, 40, -1, -1, -1, 1);
    quiet2();
    step(1'b1, 1'b0, "after_ceiling");
    pushK("after_ceiling_k", 1, 41, -1, -1, -1, 1);
    quiet2();

    guard = 0;
    while (mSt == 1 && guard < 200) begin
      frame(1'b0, "drop");
      guard++;
    end
    if (mSt != 2) boundFail("ground_crash");
    for (int k = 0; k < 5; k++) frame(1'b0, "dead_frozen");

    step(1'b1, 1'b1, "restart");
    pushK("restart_k", 0, 240, 670, 1010, 300, 1);
    quiet2();

    // Second game: hover too high for pipe0's gap and hit it.
    step(1'b1, 1'b1, "start2");
    pushK("start2_k", 1, 232, -1, -1, -1, 0);
    quiet2();
    guard = 0;
    while (mSt == 1 && guard < 400) begin
      frame(mY > 150, "hover_high");
      guard++;
    end
    if (mSt != 2) boundFail("pipe_crash");
    for (int k = 0; k < 3; k++) frame(1'b0, "dead_frozen2");
    step(1'b1, 1'b1, "restart2");
    quiet2();

    // Third game: asynchronous reset pulse that never spans a clock edge.
    step(1'b1, 1'b1, "start3");
    quiet2();
    for (int k = 0; k < 10; k++) frame(mY > 270, "play3");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    modelReset();
    applyStep(1'b0, 1'b0, "async_reset", 1'b1);
    pushK("async_reset_k", 0, 240, 670, 1010, 300, 0);
    quiet2();
    frame(1'b0, "idle_after_reset");

    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      nBad++;
      $display("FAIL drain %0d expectations left unchecked, want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #1000000;
    nBad++;
    $display("FAIL timeout simulation did not complete within 1000000 time units");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
